// File: rtl/ahb_master_arbiter_pkg.sv
// Shared AHB encodings and arbiter state type for the master arbiter slice.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        PARK,
        OWN,
        HANDOVER
    } arb_state_t;

    // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY carry no transfer.
    function automatic logic is_transfer(input htrans_t t);
        return t[1];
    endfunction

endpackage

// File: rtl/ahb_master_arbiter_if.sv
// Bundle of master-side requests and bridge-side muxed bus signals.
interface ahb_master_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    localparam int MW = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0]            HBUSREQ;
    logic [NUM_MASTERS-1:0]            HGRANT;
    logic [MW-1:0]                     HMASTER;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] M_HADDR;
    logic [NUM_MASTERS*2-1:0]          M_HTRANS;
    logic [NUM_MASTERS-1:0]            M_HWRITE;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] M_HWDATA;
    logic                              HREADY;
    logic                              HSEL;
    logic [ADDR_WIDTH-1:0]             HADDR;
    logic [1:0]                        HTRANS;
    logic                              HWRITE;
    logic [DATA_WIDTH-1:0]             HWDATA;
    logic                              HREADY_IN;

    // Arbiter view: consumes master requests, drives the bridge.
    modport master (
        input  HBUSREQ, M_HADDR, M_HTRANS, M_HWRITE, M_HWDATA, HREADY,
        output HGRANT, HMASTER, HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY_IN
    );

    // Environment view: masters and bridge.
    modport slave (
        output HBUSREQ, M_HADDR, M_HTRANS, M_HWRITE, M_HWDATA, HREADY,
        input  HGRANT, HMASTER, HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY_IN
    );

endinterface

// File: rtl/ahb_master_arbiter_rr_picker.sv
// Combinational round-robin search: first requester at or after ptr.
module rr_picker #(
    parameter int NUM_MASTERS = 2,
    localparam int MW = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MW-1:0]          ptr,
    output logic [MW-1:0]          pick,
    output logic                   valid
);

    // Scan from the far end back toward ptr so the nearest requester wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        pick  = '0;
        valid = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(ptr) + i) % NUM_MASTERS;
            if (req[idx]) begin
                pick  = idx[MW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB master arbiter with pipelined address/data ownership.
module ahb_master_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_BEATS   = 16
) (
    input  logic HCLK,
    input  logic HRESETn,
    ahb_master_arbiter_if.master bus
);

    localparam int MW = $clog2(NUM_MASTERS);
    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BEATS);

    arb_state_t      state_q, state_d;
    logic [MW-1:0]   hmaster_q, hmaster_d;
    logic [MW-1:0]   data_master_q, data_master_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [MW-1:0]   rr_ptr_q, rr_ptr_d;

    htrans_t                htrans_mux;
    logic [NUM_MASTERS-1:0] owner_mask;
    logic [MW-1:0]          pick_all, pick_oth;
    logic                   pick_all_valid, pick_oth_valid;
    logic                   accepted;

    function automatic logic [MW-1:0] next_ptr(input logic [MW-1:0] idx);
        return (int'(idx) == NUM_MASTERS - 1) ? '0 : idx + 1'b1;
    endfunction

    // Any requester, used when leaving PARK.
    rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_pick_all (
        .req   (bus.HBUSREQ),
        .ptr   (rr_ptr_q),
        .pick  (pick_all),
        .valid (pick_all_valid)
    );

    // Requesters other than the current owner, used on release and handover.
    rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_pick_oth (
        .req   (bus.HBUSREQ & ~owner_mask),
        .ptr   (rr_ptr_q),
        .pick  (pick_oth),
        .valid (pick_oth_valid)
    );

    // Address-phase mux driven by the address owner; data mux by the data owner.
    always_comb begin
        htrans_mux = htrans_t'(bus.M_HTRANS[int'(hmaster_q)*2 +: 2]);
        bus.HADDR  = bus.M_HADDR[int'(hmaster_q)*ADDR_WIDTH +: ADDR_WIDTH];
        bus.HWRITE = bus.M_HWRITE[hmaster_q];
        bus.HWDATA = bus.M_HWDATA[int'(data_master_q)*DATA_WIDTH +: DATA_WIDTH];
    end

    assign bus.HTRANS    = htrans_mux;
    assign bus.HSEL      = is_transfer(htrans_mux);
    assign bus.HREADY_IN = bus.HREADY;
    assign bus.HMASTER   = hmaster_q;
    assign accepted      = bus.HREADY && is_transfer(htrans_mux);

    // One-hot owner; the grant is withdrawn for the whole handover.
    always_comb begin
        owner_mask            = '0;
        owner_mask[hmaster_q] = 1'b1;
        bus.HGRANT            = (state_q == HANDOVER) ? '0 : owner_mask;
    end

    // Next-state logic; nothing moves while the bridge inserts wait states.
    always_comb begin
        state_d       = state_q;
        hmaster_d     = hmaster_q;
        data_master_d = data_master_q;
        beat_cnt_d    = beat_cnt_q;
        rr_ptr_d      = rr_ptr_q;
        if (bus.HREADY) begin
            data_master_d = hmaster_q;
            unique case (state_q)
                PARK: begin
                    if (pick_all_valid) begin
                        state_d    = OWN;
                        beat_cnt_d = '0;
                        if (pick_all != hmaster_q) begin
                            hmaster_d = pick_all;
                            rr_ptr_d  = next_ptr(pick_all);
                        end
                    end
                end
                OWN: begin
                    if (accepted && beat_cnt_q != MAX_CNT)
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    if (!bus.HBUSREQ[hmaster_q] && htrans_mux == IDLE) begin
                        if (pick_oth_valid) begin
                            hmaster_d  = pick_oth;
                            rr_ptr_d   = next_ptr(pick_oth);
                            beat_cnt_d = '0;
                        end else begin
                            state_d = PARK;
                        end
                    end else if (beat_cnt_d == MAX_CNT && pick_oth_valid) begin
                        state_d = HANDOVER;
                    end
                end
                HANDOVER: begin
                    if (htrans_mux == IDLE) begin
                        if (pick_oth_valid) begin
                            state_d    = OWN;
                            hmaster_d  = pick_oth;
                            rr_ptr_d   = next_ptr(pick_oth);
                            beat_cnt_d = '0;
                        end else if (bus.HBUSREQ[hmaster_q]) begin
                            state_d    = OWN;
                            beat_cnt_d = '0;
                        end else begin
                            state_d = PARK;
                        end
                    end
                end
                default: state_d = PARK;
            endcase
        end
    end

    // State registers; master 0 is parked out of reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= PARK;
            hmaster_q     <= '0;
            data_master_q <= '0;
            beat_cnt_q    <= '0;
            rr_ptr_q      <= MW'(1);
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            state_q       <= state_d;
            hmaster_q     <= hmaster_d;
            data_master_q <= data_master_d;
            beat_cnt_q    <= beat_cnt_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter with two masters and MAX_BEATS=4.
module tb_ahb_master_arbiter;
    import ahb_pkg::*;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 4;

    logic HCLK = 1'b0;
    logic HRESETn;
    int   checks = 0;
    int   errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_master_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ahb_master_arbiter #(
        .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BEATS(MB)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic set_master(input int i, input logic [1:0] t, input logic [AW-1:0] a,
                              input logic w, input logic [DW-1:0] d);
        bus.M_HTRANS[i*2 +: 2]  = t;
        bus.M_HADDR[i*AW +: AW] = a;
        bus.M_HWRITE[i]         = w;
        bus.M_HWDATA[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        HRESETn     = 1'b0;
        bus.HBUSREQ = '0;
        bus.HREADY  = 1'b1;
        set_master(0, IDLE, '0, 1'b0, 32'h1234_5678);
        set_master(1, IDLE, '0, 1'b0, 32'h0BAD_BAD0);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        HRESETn     = 1'b0;
        bus.HBUSREQ = '0;
        bus.HREADY  = 1'b1;
        set_master(0, IDLE, '0, 1'b0, '0);
        set_master(1, IDLE, '0, 1'b0, '0);
        #12;
        checks++; if (bus.HGRANT !== 2'b01) begin errors++; $display("FAIL rst_hgrant: got %b want 01", bus.HGRANT); end
        checks++; if (bus.HMASTER !== 1'b0) begin errors++; $display("FAIL rst_hmaster: got %b want 0", bus.HMASTER); end
        checks++; if (dut.state_q !== PARK) begin errors++; $display("FAIL rst_state: got %0d want PARK", dut.state_q); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        tick();
        tick();
        checks++; if (bus.HGRANT !== 2'b01) begin errors++; $display("FAIL post_rst_hgrant: got %b want 01", bus.HGRANT); end
        checks++; if (dut.state_q !== PARK) begin errors++; $display("FAIL post_rst_state: got %0d want PARK", dut.state_q); end
        checks++; if (bus.HSEL !== 1'b0) begin errors++; $display("FAIL post_rst_hsel: got %b want 0", bus.HSEL); end
    endtask

    task automatic test_single_write();
        do_reset();
        bus.HBUSREQ = 2'b10;
        tick();
        checks++; if (bus.HGRANT !== 2'b10) begin errors++; $display("FAIL sw_grant: got %b want 10", bus.HGRANT); end
        set_master(1, NONSEQ, 32'h04, 1'b1, '0);
        #1;
        checks++; if (bus.HADDR !== 32'h04) begin errors++; $display("FAIL sw_haddr: got %h want 00000004", bus.HADDR); end
        checks++; if (bus.HTRANS !== 2'b10) begin errors++; $display("FAIL sw_htrans: got %b want 10", bus.HTRANS); end
        checks++; if (bus.HSEL !== 1'b1) begin errors++; $display("FAIL sw_hsel: got %b want 1", bus.HSEL); end
        checks++; if (bus.HWRITE !== 1'b1) begin errors++; $display("FAIL sw_hwrite: got %b want 1", bus.HWRITE); end
        tick();
        bus.HBUSREQ = 2'b00;
        set_master(1, IDLE, 32'h04, 1'b1, 32'hDEAD_BEEF);
        #1;
        checks++; if (bus.HWDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_hwdata: got %h want deadbeef", bus.HWDATA); end
        checks++; if (dut.data_master_q !== 1'b1) begin errors++; $display("FAIL sw_data_master: got %b want 1", dut.data_master_q); end
        tick();
        checks++; if (dut.state_q !== PARK) begin errors++; $display("FAIL sw_park: got %0d want PARK", dut.state_q); end
        checks++; if (bus.HGRANT !== 2'b10) begin errors++; $display("FAIL sw_park_grant: got %b want 10", bus.HGRANT); end
        // Asynchronous reset while master 1 owns the bus.
        #2;
        HRESETn = 1'b0;
        #1;
        checks++; if (bus.HGRANT !== 2'b01) begin errors++; $display("FAIL async_rst_grant: got %b want 01", bus.HGRANT); end
        checks++; if (bus.HMASTER !== 1'b0) begin errors++; $display("FAIL async_rst_hmaster: got %b want 0", bus.HMASTER); end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.HBUSREQ = 2'b11;
        tick();
        checks++; if (bus.HMASTER !== 1'b1) begin errors++; $display("FAIL rr_round1: got %b want 1", bus.HMASTER); end
        bus.HBUSREQ = 2'b01;
        tick();
        checks++; if (bus.HMASTER !== 1'b0) begin errors++; $display("FAIL rr_round2: got %b want 0", bus.HMASTER); end
        checks++; if (bus.HGRANT !== 2'b01) begin errors++; $display("FAIL rr_round2_grant: got %b want 01", bus.HGRANT); end
        bus.HBUSREQ = 2'b10;
        tick();
        checks++; if (bus.HMASTER !== 1'b1) begin errors++; $display("FAIL rr_round3: got %b want 1", bus.HMASTER); end
    endtask

    task automatic test_forced_handover();
        do_reset();
        bus.HBUSREQ = 2'b01;
        tick();
        bus.HBUSREQ = 2'b11;
        set_master(0, NONSEQ, 32'h100, 1'b1, '0);
        tick();
        set_master(0, SEQ, 32'h104, 1'b1, '0);
        tick();
        set_master(0, SEQ, 32'h108, 1'b1, '0);
        tick();
        checks++; if (bus.HGRANT !== 2'b01) begin errors++; $display("FAIL ho_beat3_grant: got %b want 01", bus.HGRANT); end
        set_master(0, SEQ, 32'h10C, 1'b1, '0);
        tick();
        checks++; if (bus.HGRANT[0] !== 1'b0) begin errors++; $display("FAIL ho_beat4_grant: got %b want 0", bus.HGRANT[0]); end
        checks++; if (bus.HMASTER !== 1'b0) begin errors++; $display("FAIL ho_held: got %b want 0", bus.HMASTER); end
        set_master(0, SEQ, 32'h110, 1'b1, '0);
        tick();
        checks++; if (bus.HMASTER !== 1'b0) begin errors++; $display("FAIL ho_inflight: got %b want 0", bus.HMASTER); end
        set_master(0, IDLE, 32'h110, 1'b1, '0);
        tick();
        checks++; if (bus.HMASTER !== 1'b1) begin errors++; $display("FAIL ho_switch: got %b want 1", bus.HMASTER); end
        checks++; if (bus.HGRANT !== 2'b10) begin errors++; $display("FAIL ho_switch_grant: got %b want 10", bus.HGRANT); end
    endtask

    task automatic test_wait_states();
        do_reset();
        bus.HBUSREQ = 2'b01;
        tick();
        bus.HBUSREQ = 2'b11;
        set_master(0, NONSEQ, 32'h40, 1'b1, '0);
        tick();
        bus.HBUSREQ = 2'b10;
        bus.HREADY  = 1'b0;
        set_master(0, IDLE, 32'h40, 1'b1, 32'hCAFE_F00D);
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (bus.HMASTER !== 1'b0) begin errors++; $display("FAIL ws_hmaster[%0d]: got %b want 0", c, bus.HMASTER); end
            checks++; if (bus.HGRANT !== 2'b01) begin errors++; $display("FAIL ws_grant[%0d]: got %b want 01", c, bus.HGRANT); end
            checks++; if (dut.data_master_q !== 1'b0) begin errors++; $display("FAIL ws_data_master[%0d]: got %b want 0", c, dut.data_master_q); end
            checks++; if (bus.HWDATA !== 32'hCAFE_F00D) begin errors++; $display("FAIL ws_hwdata[%0d]: got %h want cafef00d", c, bus.HWDATA); end
            checks++; if (bus.HREADY_IN !== 1'b0) begin errors++; $display("FAIL ws_hready_in[%0d]: got %b want 0", c, bus.HREADY_IN); end
        end
        bus.HREADY = 1'b1;
        tick();
        checks++; if (bus.HGRANT !== 2'b10) begin errors++; $display("FAIL ws_release_grant: got %b want 10", bus.HGRANT); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.HBUSREQ = 2'b10;
        set_master(0, NONSEQ, 32'h10, 1'b1, '0);
        tick();
        bus.HBUSREQ = 2'b10;
        set_master(0, IDLE, 32'h10, 1'b1, 32'h1111_1111);
        set_master(1, NONSEQ, 32'h20, 1'b0, 32'h2222_2222);
        #1;
        checks++; if (bus.HMASTER !== 1'b1) begin errors++; $display("FAIL b2b_hmaster: got %b want 1", bus.HMASTER); end
        checks++; if (bus.HADDR !== 32'h20) begin errors++; $display("FAIL b2b_haddr: got %h want 00000020", bus.HADDR); end
        checks++; if (bus.HWRITE !== 1'b0) begin errors++; $display("FAIL b2b_hwrite: got %b want 0", bus.HWRITE); end
        checks++; if (bus.HWDATA !== 32'h1111_1111) begin errors++; $display("FAIL b2b_hwdata: got %h want 11111111", bus.HWDATA); end
        set_master(1, IDLE, 32'h20, 1'b0, 32'h2222_2222);
        tick();
        checks++; if (bus.HWDATA !== 32'h2222_2222) begin errors++; $display("FAIL b2b_hwdata_m1: got %h want 22222222", bus.HWDATA); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_forced_handover();
        test_wait_states();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
